aabb_pair_sweep: RTL and testbench

AABB_PAIR_SWEEP -- requirements
Module: aabb_pair_sweep

---
 rtl/aabb_pair_sweep.sv | 172 +++++++++++++++++
 tb/tb_aabb_pair_sweep.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aabb_pair_sweep.sv
// Collects a frame of up to N_MAX axis-aligned boxes, then sweeps every (i,j) pair once,
// presenting overlapping pairs in lexicographic order over a valid/ready handshake.
module aabb_pair_sweep #(
    parameter int N_MAX = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_aabb0,
    input  logic [31:0]      in_aabb1,
    input  logic [31:0]      in_aabb2,
    input  logic [31:0]      in_aabb3,
    input  logic [31:0]      in_aabb4,
    input  logic [31:0]      in_aabb5,
    input  logic             in_last,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             sweep_done,
    output logic [7:0]       pair_count
);

    typedef enum logic [1:0] {
        LOAD,
        SWEEP,
        EMIT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [IDX_W:0]   cnt;
    logic [IDX_W-1:0] idx_i, idx_j;
    logic [IDX_W-1:0] i_adv, j_adv;
    logic             j_at_end, last_pair;
    logic             accept, load_exit, overlap;

    logic [31:0]      box_min [N_MAX][3];
    logic [31:0]      box_max [N_MAX][3];
    logic [N_MAX-1:0] box_nan;

    function automatic logic is_nan(input logic [31:0] f);
        is_nan = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    // Sign-magnitude ordering on raw bits; +0 and -0 compare equal.
    function automatic logic f_le(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            r = 1'b1;
        else if (a[31] != b[31])
            r = a[31];
        else if (!a[31])
            r = (a[30:0] <= b[30:0]);
        else
            r = (a[30:0] >= b[30:0]);
        f_le = r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign load_exit = in_last || (cnt == (IDX_W+1)'(N_MAX - 1));
    assign j_at_end  = ({1'b0, idx_j} == (cnt - (IDX_W+1)'(1)));
    assign last_pair = j_at_end && ({1'b0, idx_i} == (cnt - (IDX_W+1)'(2)));
    assign i_adv     = j_at_end ? (idx_i + IDX_W'(1)) : idx_i;
    assign j_adv     = j_at_end ? (idx_i + IDX_W'(2)) : (idx_j + IDX_W'(1));

    // The frame store carries no reset; cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            box_min[cnt[IDX_W-1:0]][0] <= in_aabb0;
            box_max[cnt[IDX_W-1:0]][0] <= in_aabb1;
            box_min[cnt[IDX_W-1:0]][1] <= in_aabb2;
            box_max[cnt[IDX_W-1:0]][1] <= in_aabb3;
            box_min[cnt[IDX_W-1:0]][2] <= in_aabb4;
            box_max[cnt[IDX_W-1:0]][2] <= in_aabb5;
            box_nan[cnt[IDX_W-1:0]]    <= is_nan(in_aabb0) | is_nan(in_aabb1) |
                                          is_nan(in_aabb2) | is_nan(in_aabb3) |
                                          is_nan(in_aabb4) | is_nan(in_aabb5);
        end
    end

    always_comb begin
        overlap = !box_nan[idx_i] && !box_nan[idx_j];
        for (int a = 0; a < 3; a++) begin
            overlap = overlap &&
                      f_le(box_min[idx_i][a], box_max[idx_j][a]) &&
                      f_le(box_min[idx_j][a], box_max[idx_i][a]);
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        pair_valid = 1'b0;
        sweep_done = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (accept && load_exit)
                    state_next = (cnt == '0) ? DONE : SWEEP;
            end
            SWEEP: begin
                if (overlap)
                    state_next = EMIT;
                else if (last_pair)
                    state_next = DONE;
            end
            EMIT: begin
                pair_valid = 1'b1;
                if (pair_ready)
                    state_next = last_pair ? DONE : SWEEP;
            end
            DONE: begin
                sweep_done = 1'b1;
                state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // idx_i/idx_j stay parked during EMIT so the handshake can advance from the emitted pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            cnt        <= '0;
            pair_count <= '0;
            pair_i     <= '0;
            pair_j     <= '0;
            idx_i      <= '0;
            idx_j      <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (accept) begin
                        cnt <= cnt + (IDX_W+1)'(1);
                        if (cnt == '0)
                            pair_count <= '0;
                        if (load_exit) begin
                            idx_i <= '0;
                            idx_j <= IDX_W'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (overlap) begin
                        pair_i <= idx_i;
                        pair_j <= idx_j;
                    end else if (!last_pair) begin
                        idx_i <= i_adv;
                        idx_j <= j_adv;
                    end
                end
                EMIT: begin
                    if (pair_ready) begin
                        pair_count <= pair_count + 8'd1;
                        if (!last_pair) begin
                            idx_i <= i_adv;
                            idx_j <= j_adv;
                        end
                    end
                end
                DONE: cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aabb_pair_sweep.sv
// Self-checking bench for aabb_pair_sweep: directed corner frames plus random frames
// compared against a real-valued overlap model.
module tb_aabb_pair_sweep;

    localparam int N_MAX = 8;
    localparam int IDX_W = 3;

    localparam logic [31:0] POOL [11] = '{
        32'hC0000000, 32'hBF800000, 32'hBF000000, 32'h80000000, 32'h00000000,
        32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
        32'h40800000
    };

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_aabb0, in_aabb1, in_aabb2, in_aabb3, in_aabb4, in_aabb5;
    logic             in_last;
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] pair_i, pair_j;
    logic             sweep_done;
    logic [7:0]       pair_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fb [N_MAX][6];
    int          exp_q [$];

    aabb_pair_sweep #(.N_MAX(N_MAX), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_aabb0  (in_aabb0),
        .in_aabb1  (in_aabb1),
        .in_aabb2  (in_aabb2),
        .in_aabb3  (in_aabb3),
        .in_aabb4  (in_aabb4),
        .in_aabb5  (in_aabb5),
        .in_last   (in_last),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .pair_i    (pair_i),
        .pair_j    (pair_j),
        .sweep_done(sweep_done),
        .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        int  e;
        real m, v;
        e = int'(f[30:23]);
        m = real'(int'(f[22:0]));
        if (e == 255)
            v = 1.0e300;
        else if (e == 0)
            v = m * (2.0 ** (-149));
        else
            v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -v : v;
    endfunction

    function automatic bit box_has_nan(input int k);
        bit r = 0;
        for (int b = 0; b < 6; b++)
            if (fb[k][b][30:23] == 8'hFF && fb[k][b][22:0] != 23'd0) r = 1;
        return r;
    endfunction

    function automatic bit model_overlap(input int a, input int b);
        bit r;
        if (box_has_nan(a) || box_has_nan(b)) return 0;
        r = 1;
        for (int ax = 0; ax < 3; ax++) begin
            if (!(f2r(fb[a][2*ax]) <= f2r(fb[b][2*ax+1]))) r = 0;
            if (!(f2r(fb[b][2*ax]) <= f2r(fb[a][2*ax+1]))) r = 0;
        end
        return r;
    endfunction

    task automatic build_expected(input int n);
        exp_q.delete();
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (model_overlap(a, b)) exp_q.push_back((a << IDX_W) | b);
    endtask

    task automatic set_box(input int k, input logic [31:0] x0, input logic [31:0] x1,
                           input logic [31:0] y0, input logic [31:0] y1,
                           input logic [31:0] z0, input logic [31:0] z1);
        fb[k][0] = x0; fb[k][1] = x1; fb[k][2] = y0;
        fb[k][3] = y1; fb[k][4] = z0; fb[k][5] = z1;
    endtask

    task automatic apply_stimulus(input int n, input bit use_last);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_aabb0 = fb[k][0]; in_aabb1 = fb[k][1]; in_aabb2 = fb[k][2];
            in_aabb3 = fb[k][3]; in_aabb4 = fb[k][4]; in_aabb5 = fb[k][5];
            in_last  = use_last && (k == n - 1);
            check_output("in_ready_load", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit use_last, input int stall, input string name);
        int cycles = 0;
        int got    = 0;
        bit done   = 0;
        logic [31:0] want;
        build_expected(n);
        apply_stimulus(n, use_last);
        check_output({name, "/count_clear"}, 32'(pair_count), 32'd0);
        pair_ready = (stall == 0);
        while (!done && cycles < 2000) begin
            if (sweep_done) begin
                done = 1;
            end else if (pair_valid) begin
                want = (got < exp_q.size()) ? exp_q[got] : 32'hFFFF_FFFF;
                check_output({name, "/pair"}, 32'({pair_i, pair_j}), want);
                got++;
                if (stall > 0) begin
                    for (int s = 0; s < stall; s++) begin
                        step();
                        cycles++;
                        check_output({name, "/stall_hold"}, 32'({pair_valid, pair_i, pair_j}),
                                     (32'd1 << (2*IDX_W)) | want);
                    end
                    pair_ready = 1'b1;
                    step();
                    cycles++;
                    pair_ready = 1'b0;
                end else begin
                    step();
                    cycles++;
                end
            end else begin
                step();
                cycles++;
            end
        end
        check_output({name, "/sweep_done_seen"}, 32'(done), 32'd1);
        check_output({name, "/pairs_emitted"}, 32'(got), 32'(exp_q.size()));
        check_output({name, "/pair_count"}, 32'(pair_count), 32'(exp_q.size()));
        if (stall == 0 && done)
            check_output({name, "/latency"}, 32'(cycles <= n*(n-1)/2 + exp_q.size() + 2), 32'd1);
        pair_ready = 1'b0;
        step();
        check_output({name, "/done_one_cycle"}, 32'(sweep_done), 32'd0);
        check_output({name, "/ready_after_done"}, 32'(in_ready), 32'd1);
        check_output({name, "/count_hold"}, 32'(pair_count), 32'(exp_q.size()));
    endtask

    task automatic random_box(input int k);
        int a, b;
        for (int ax = 0; ax < 3; ax++) begin
            a = $urandom_range(0, 10);
            b = $urandom_range(0, 10);
            fb[k][2*ax]   = POOL[(a < b) ? a : b];
            fb[k][2*ax+1] = POOL[(a < b) ? b : a];
        end
        if ($urandom_range(0, 15) == 0)
            fb[k][$urandom_range(0, 5)] = ($urandom_range(0, 1) == 0) ? 32'h7FC00000 : 32'hFF800001;
    endtask

    initial begin
        int guard;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        pair_ready = 1'b0;
        in_aabb0 = '0; in_aabb1 = '0; in_aabb2 = '0;
        in_aabb3 = '0; in_aabb4 = '0; in_aabb5 = '0;
        repeat (3) step();
        check_output("reset/in_ready", 32'(in_ready), 32'd1);
        check_output("reset/pair_valid", 32'(pair_valid), 32'd0);
        check_output("reset/sweep_done", 32'(sweep_done), 32'd0);
        check_output("reset/pair_count", 32'(pair_count), 32'd0);
        check_output("reset/pair_idx", 32'({pair_i, pair_j}), 32'd0);
        rst = 1'b1;
        step();

        // three boxes, one overlap
        set_box(0, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        set_box(1, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h40000000);
        set_box(2, 32'h40A00000, 32'h40C00000, 32'h40A00000, 32'h40C00000, 32'h40A00000, 32'h40C00000);
        check_output("three/model_pairs", 32'(exp_q.size()), 32'd0);
        run_frame(3, 1'b1, 0, "three");
        check_output("three/model_agrees", 32'(exp_q.size()), 32'd1);

        // touching faces, plus a box one ulp past the touching bound
        set_box(0, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        set_box(1, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h40000000);
        set_box(2, 32'h3F800001, 32'h40000000, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h40000000);
        run_frame(3, 1'b1, 1, "touch");

        // eight identical boxes, no last flag, heavy backpressure
        for (int k = 0; k < N_MAX; k++)
            set_box(k, 32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000);
        run_frame(N_MAX, 1'b0, 5, "eight");

        // signed zeros touch; NaN box pairs with nothing
        set_box(0, 32'hBF800000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        set_box(1, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        set_box(2, 32'h7FC00000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        run_frame(3, 1'b1, 0, "zeros_nan");

        set_box(0, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        run_frame(1, 1'b1, 0, "single");

        // reset while a pair is pending, with junk beats offered during reset
        set_box(0, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000);
        set_box(1, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h40000000, 32'h3F000000, 32'h40000000);
        apply_stimulus(2, 1'b1);
        guard = 0;
        while (!pair_valid && guard < 10) begin
            step();
            guard++;
        end
        check_output("midreset/pair_pending", 32'(pair_valid), 32'd1);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_aabb0 = 32'h7FC00000;
        step();
        check_output("midreset/pair_valid", 32'(pair_valid), 32'd0);
        check_output("midreset/in_ready", 32'(in_ready), 32'd1);
        check_output("midreset/sweep_done", 32'(sweep_done), 32'd0);
        check_output("midreset/pair_idx", 32'({pair_i, pair_j}), 32'd0);
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        run_frame(2, 1'b1, 0, "after_reset");

        for (int f = 0; f < 40; f++) begin
            int  n;
            bit  use_last;
            n        = $urandom_range(1, N_MAX);
            use_last = (n < N_MAX) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) random_box(k);
            run_frame(n, use_last, $urandom_range(0, 2), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
